disp_share_arb: RTL

DISP_SHARE_ARB -- requirements
Module: disp_share_arb

---
 rtl/disp_share_arb_if.sv | 33 +++
 rtl/disp_share_arb.sv | 129 ++++++++++++
 2 files changed

// File: rtl/disp_share_arb_if.sv
// Bundles the shared-display arbiter's request and display signals.
//   master : request side, drives req/data_in/neg_in and observes the display outputs
//   slave  : arbiter side, samples the requests and drives grant/ack/disp_*/src_id
//   req[3:0]        request per source
//   data_in[15:0]   4-bit value of source i on bits [4i+3:4i]
//   neg_in[3:0]     sign/mode flag per source
//   grant[3:0]      one-hot of the source being shown, or 0
//   ack             one-cycle pulse on the last dwell cycle
//   disp_val[3:0]   value presented to the shared 7-segment decoder
//   disp_neg        sign flag presented to the shared decoder
//   disp_valid      disp_val/disp_neg hold a granted snapshot
//   src_id[1:0]     binary index of the granted source
interface disp_share_arb_if;
   logic [3:0]  req;
   logic [15:0] data_in;
   logic [3:0]  neg_in;
   logic [3:0]  grant;
   logic        ack;
   logic [3:0]  disp_val;
   logic        disp_neg;
   logic        disp_valid;
   logic [1:0]  src_id;

   modport master (
      output req, data_in, neg_in,
      input  grant, ack, disp_val, disp_neg, disp_valid, src_id
   );

   modport slave (
      input  req, data_in, neg_in,
      output grant, ack, disp_val, disp_neg, disp_valid, src_id
   );
endinterface

// File: rtl/disp_share_arb.sv
// Time-shares one 7-segment decoder between four sources. A round-robin
// arbiter picks a requester in IDLE, snapshots its value and sign, and shows
// it for DWELL cycles before returning to IDLE for at least one cycle.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : disp_share_arb_if.slave (req, data_in, neg_in in;
//            grant, ack, disp_val, disp_neg, disp_valid, src_id out)
// Parameter:
//   DWELL  : cycles each granted value is shown, 2 .. 2^25-1
//
// state | meaning
// IDLE  | no grant; arbitrate among requesters, display outputs hold last value
// SHOW  | one source granted; dwell counter runs down to 0, ack on the last cycle
module disp_share_arb #(
   parameter int unsigned DWELL = 25000000
) (
   input  logic             clk,
   input  logic             rst_n,
   disp_share_arb_if.slave  bus
);

   typedef enum logic {IDLE, SHOW} state_t;

   localparam logic [24:0] CNT_LOAD = 25'(DWELL - 1);

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [24:0] cnt_q, cnt_d;
   logic [3:0]  grant_q, grant_d;
   logic        ack_q, ack_d;
   logic [3:0]  val_q, val_d;
   logic        neg_q, neg_d;
   logic        valid_q, valid_d;
   logic [1:0]  id_q, id_d;

   logic        found;
   logic [1:0]  win;

   // Round-robin search starting one past the last winner; the 2-bit add
   // wraps 3->0 naturally. The last winner is only reached after the other
   // three, which puts a still-requesting source at lowest priority.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         if (!found && bus.req[ptr_q + 2'(k)]) begin
            found = 1'b1;
            win   = ptr_q + 2'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ack_d   = 1'b0;
      val_d   = val_q;
      neg_d   = neg_q;
      valid_d = valid_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            grant_d = 4'b0000;
            valid_d = 1'b0;
            if (found) begin
               state_d = SHOW;
               grant_d = 4'b0001 << win;
               id_d    = win;
               valid_d = 1'b1;
               ptr_d   = win;
               cnt_d   = CNT_LOAD;
               val_d   = bus.data_in[{win, 2'b00} +: 4];
               neg_d   = bus.neg_in[win];
            end
         end
         SHOW: begin
            if (cnt_q != 25'd0) begin
               cnt_d = cnt_q - 25'd1;
               // ack is registered, so raise it on the edge where the count lands on 0
               ack_d = (cnt_q == 25'd1);
            end else begin
               state_d = IDLE;
               grant_d = 4'b0000;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         cnt_q   <= 25'd0;
         grant_q <= 4'b0000;
         ack_q   <= 1'b0;
         val_q   <= 4'b0000;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
         id_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         val_q   <= val_d;
         neg_q   <= neg_d;
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.ack        = ack_q;
   assign bus.disp_val   = val_q;
   assign bus.disp_neg   = neg_q;
   assign bus.disp_valid = valid_q;
   assign bus.src_id     = id_q;

endmodule
